popcount_seq_ctrl: RTL and testbench
====================================

// Module: popcount_seq_ctrl
// PURPOSE
//  Sequencer wrapped around a 3-bit population-count unit (3b in -> 2b count).
//  - Accepts one DATA_W-bit word over a valid/ready handshake.
//  - Feeds the word through the popcount3 unit one 3-bit chunk per cycle, LSB chunk first.
//  - Accumulates the chunk counts and presents the total on a valid/ready output.
//  - Lets one small popcount3 datapath serve arbitrary word widths in a streaming pipeline.
// PARAMETERS
//  DATA_W   12                     input word width, >= 1
//  NCHUNK   (DATA_W+2)/3           derived (localparam): number of 3-bit chunks
//  CNT_W    $clog2(DATA_W+1)       derived (localparam): width of the result count
// PORTS
//  clk        in   1        clock; all state updates on rising edge
//  areset     in   1        asynchronous, active-high reset
//  in_valid   in   1        input word valid
//  in_ready   out  1        block can accept a word this cycle
//  in_data    in   DATA_W   input word; sampled only on the accept edge (in_valid & in_ready)
//  out_valid  out  1        out_count holds a final result
//  out_ready  in   1        downstream consumes the result
//  out_count  out  CNT_W    number of 1 bits in the accepted word
//  busy       out  1        high in state RUN
// BEHAVIOUR
//  Reset:
//  - areset clears to state IDLE; shift register, accumulator and chunk counter = 0.
//  - Outputs under reset: in_ready=1, out_valid=0, out_count=0, busy=0.
//  - Reset takes effect immediately and asynchronously in any state.
//  - A word that is in flight when reset asserts is discarded; no partial result appears.
//  FSM states IDLE, RUN, DONE:
//  - IDLE: in_ready=1. On accept:
//    - load shift reg = in_data zero-extended to 3*NCHUNK bits;
//    - clear acc and chunk counter; go to RUN.
//  - RUN: in_ready=0; in_valid is ignored. On each edge:
//    - acc += popcount3(shift[2:0]);
//    - shift >>= 3;
//    - chunk counter++.
//    - When the edge processes chunk NCHUNK-1, go to DONE.
//  - DONE: out_valid=1; out_count=acc, held stable while out_ready=0.
//    - in_ready = out_ready.
//    - out_ready & in_valid: the result is consumed and the new word loaded on the same edge; go to RUN.
//    - out_ready & !in_valid: go to IDLE.
//  Latency and throughput:
//  - out_valid rises exactly NCHUNK edges after the accept edge.
//  - Back-to-back words with out_ready held at 1: one word every NCHUNK+1 cycles.
//  Arithmetic:
//  - acc is CNT_W bits and never overflows, since the maximum value is DATA_W.
//  - Padding bits in the top chunk are zero, so they never contribute to the count.
//  - The chunk counter is $clog2(NCHUNK+1) bits. It saturates at NCHUNK and never wraps.
//  Output timing:
//  - out_count is registered and is 0 in IDLE and RUN.
//  - in_ready is combinational from state (and from out_ready in DONE); no other path from input to output.
// STRUCTURE
//  Package popcount_pkg:
//  - state_t enum {IDLE, RUN, DONE};
//  - localparam CHUNK_W = 3;
//  - function nchunk(int w) = (w+CHUNK_W-1)/CHUNK_W.
//  Sub-module popcount3_unit:
//  - combinational; din[2:0] -> dout[1:0] = number of set bits;
//  - instantiated exactly once on shift[2:0].
//  Top level holds the FSM, the shift register, the accumulator and the chunk counter.
// TESTING  (DATA_W=12 unless stated)
//  1. Reset: assert areset for 2 cycles, then idle.
//     -> in_ready=1, out_valid=0, out_count=0, busy=0.
//  2. Accept 12'hFFF, out_ready=1.
//     -> busy=1 for 4 cycles; out_valid=1 4 edges after accept with out_count=12.
//  3. Values, each accepted from IDLE:
//     -> 12'h000 -> 0; 12'hA5A -> 6; 12'h001 -> 1; 12'h800 -> 1.
//  4. Back-to-back: in_valid and out_ready held at 1 with words 12'h0F0 then 12'h777.
//     -> results 4 then 9; the second word is accepted on the DONE edge; period 5 cycles.
//  5. Backpressure: hold out_ready=0 for 10 cycles in DONE.
//     -> out_valid and out_count stay stable, in_ready=0; one cycle after out_ready=1 the block is in IDLE.
//  6. Reset mid-RUN after 2 chunks of 12'hFFF; release reset, then accept 12'h003.
//     -> no stale output; out_count=2.
//     DATA_W=8 variant: 8'hFF -> 8 after 3 edges, with padding ignored.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount sequencer.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Bits examined by the popcount datapath per cycle
  localparam int unsigned CHUNK_W = 3;

  // Number of CHUNK_W-bit chunks needed to cover a w-bit word
  function automatic int unsigned nchunk(input int unsigned w);
    return (w + CHUNK_W - 1) / CHUNK_W;
  endfunction

endpackage

// File: rtl/popcount3_unit.sv
// Combinational 3-bit population count: number of set bits in din.
module popcount3_unit (
  input  logic [2:0] din,
  output logic [1:0] dout
);

  assign dout = {1'b0, din[0]} + {1'b0, din[1]} + {1'b0, din[2]};

endmodule

// File: rtl/popcount_seq_ctrl.sv
// Sequencer that counts the set bits of a DATA_W-bit word by walking it through
// a single 3-bit popcount unit, one chunk per cycle, LSB chunk first.
module popcount_seq_ctrl
  import popcount_pkg::*;
#(
  parameter int unsigned DATA_W = 12
) (
  input  logic                        clk,
  input  logic                        areset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DATA_W+1)-1:0] out_count,
  output logic                        busy
);

  localparam int unsigned NCHUNK = nchunk(DATA_W);
  localparam int unsigned SH_W   = CHUNK_W * NCHUNK;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned CCNT_W = $clog2(NCHUNK + 1);
  // Adder wide enough for both the accumulator and a 2-bit chunk count
  localparam int unsigned SUM_W  = (CNT_W > 2) ? CNT_W : 2;

  localparam logic [CCNT_W-1:0] LAST_CHUNK = CCNT_W'(NCHUNK - 1);
  localparam logic [CCNT_W-1:0] MAX_CHUNK  = CCNT_W'(NCHUNK);

  state_t              state_q, state_d;
  logic [SH_W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [CCNT_W-1:0]   chunk_q, chunk_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [1:0]          chunk_pop;
  logic [SUM_W-1:0]    sum;
  logic                accept;
  logic                last_chunk;

  popcount3_unit u_popcount3 (
    .din  (shift_q[2:0]),
    .dout (chunk_pop)
  );

  assign sum        = SUM_W'(acc_q) + SUM_W'(chunk_pop);
  assign accept     = in_valid & in_ready;
  assign last_chunk = (chunk_q == LAST_CHUNK);
  assign out_count  = count_q;

  // State and datapath registers, cleared asynchronously so an in-flight word is dropped
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      chunk_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      chunk_q <= chunk_d;
      count_q <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = in_valid ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: load on accept, otherwise consume one chunk per RUN cycle
  always_comb begin
    shift_d = shift_q;
    acc_d   = acc_q;
    chunk_d = chunk_q;
    if (accept) begin
      // Zero padding in the top chunk keeps it from adding to the count
      shift_d = SH_W'(in_data);
      acc_d   = '0;
      chunk_d = '0;
    end else if (state_q == RUN) begin
      shift_d = shift_q >> CHUNK_W;
      acc_d   = CNT_W'(sum);
      chunk_d = (chunk_q == MAX_CHUNK) ? chunk_q : chunk_q + 1'b1;
    end
  end

  // Result register: captured on the final chunk, held through backpressure, else zero
  always_comb begin
    count_d = '0;
    if (state_q == RUN && last_chunk) begin
      count_d = CNT_W'(sum);
    end else if (state_q == DONE && !out_ready) begin
      count_d = count_q;
    end
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Scoreboard bench for popcount_seq_ctrl (DATA_W=12 main instance, DATA_W=8 side instance).
module tb_popcount_seq_ctrl;

  logic        clk;
  logic        areset;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_count;
  logic        busy;

  logic        in8_valid;
  logic        in8_ready;
  logic [7:0]  in8_data;
  logic        out8_valid;
  logic        out8_ready;
  logic [3:0]  out8_count;
  logic        busy8;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int exp_q[$];

  popcount_seq_ctrl #(.DATA_W(12)) dut (
    .clk       (clk),
    .areset    (areset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  popcount_seq_ctrl #(.DATA_W(8)) dut8 (
    .clk       (clk),
    .areset    (areset),
    .in_valid  (in8_valid),
    .in_ready  (in8_ready),
    .in_data   (in8_data),
    .out_valid (out8_valid),
    .out_ready (out8_ready),
    .out_count (out8_count),
    .busy      (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Monitor: every result handed downstream is compared with the oldest expectation
  always @(negedge clk) begin
    if (!areset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL result_without_word: got count %0d, expected no result", out_count);
      end else begin
        check("result", int'(out_count), exp_q.pop_front());
      end
    end
  end

  // Present a word until accepted; the expectation is queued on the accept edge
  task automatic accept_word(input logic [11:0] d, input int expected, input bit keep_valid,
                             output int cyc_at);
    int  n;
    bit  got;
    n        = 0;
    got      = 1'b0;
    cyc_at   = -1;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      n++;
    end while (!got && n < 50);
    #1;
    if (!got) check("accept_timeout", 0, 1);
    else begin
      exp_q.push_back(expected);
      cyc_at = cyc;
    end
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Count edges from the accept edge to out_valid, tracking busy and out_count meanwhile
  task automatic wait_valid(output int edges, output int busy_cnt, output bit count_clean);
    edges       = 0;
    busy_cnt    = 0;
    count_clean = 1'b1;
    while (edges < 50) begin
      @(negedge clk);
      if (out_valid) break;
      if (busy) busy_cnt++;
      if (out_count != 0) count_clean = 1'b0;
      @(posedge clk);
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] vals[4];
    int          exps[4];
    int          edges, busy_cnt, c1, c2, bad, stale, e8;
    bit          clean;

    vals = '{12'h000, 12'hA5A, 12'h001, 12'h800};
    exps = '{0, 6, 1, 1};

    areset     = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    in8_valid  = 1'b0;
    in8_data   = '0;
    out8_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_count", out_count, 0);
    check("reset_busy", busy, 0);

    // All ones: latency, busy duration, zero count while running
    @(posedge clk); #1;
    accept_word(12'hFFF, 12, 1'b0, c1);
    wait_valid(edges, busy_cnt, clean);
    check("fff_latency", edges, 4);
    check("fff_busy_cycles", busy_cnt, 4);
    check("fff_count_zero_in_run", clean, 1);
    check("fff_done_not_busy", busy, 0);
    @(posedge clk); #1;
    check("fff_back_to_idle", in_ready, 1);

    // Directed values, each from IDLE
    for (int i = 0; i < 4; i++) begin
      accept_word(vals[i], exps[i], 1'b0, c1);
      wait_valid(edges, busy_cnt, clean);
      check("value_latency", edges, 4);
      @(posedge clk); #1;
    end

    // Back-to-back with in_valid and out_ready held high
    accept_word(12'h0F0, 4, 1'b1, c1);
    accept_word(12'h777, 9, 1'b0, c2);
    check("b2b_period", c2 - c1, 5);
    wait_valid(edges, busy_cnt, clean);
    check("b2b_second_latency", edges, 4);
    @(posedge clk); #1;

    // Backpressure in DONE
    out_ready = 1'b0;
    accept_word(12'hA5A, 6, 1'b0, c1);
    wait_valid(edges, busy_cnt, clean);
    check("bp_latency", edges, 4);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || out_count != 4'd6 || in_ready) bad++;
      @(posedge clk);
    end
    check("bp_hold_stable", bad, 0);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_busy", busy, 0);

    // Reset after two chunks of an all-ones word
    accept_word(12'hFFF, 12, 1'b0, c1);
    repeat (2) @(posedge clk);
    #1 areset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrun_reset_in_ready", in_ready, 1);
    check("midrun_reset_out_valid", out_valid, 0);
    check("midrun_reset_busy", busy, 0);
    @(posedge clk); #1 areset = 1'b0;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || out_count != 0) stale++;
    end
    check("midrun_no_stale_output", stale, 0);
    @(posedge clk); #1;
    accept_word(12'h003, 2, 1'b0, c1);
    wait_valid(edges, busy_cnt, clean);
    check("post_reset_latency", edges, 4);
    @(posedge clk); #1;

    // DATA_W=8 instance: three chunks, top padding bit ignored
    in8_valid = 1'b1;
    in8_data  = 8'hFF;
    @(negedge clk);
    check("dw8_in_ready", in8_ready, 1);
    @(posedge clk); #1 in8_valid = 1'b0;
    e8 = 0;
    while (e8 < 20) begin
      @(negedge clk);
      if (out8_valid) break;
      @(posedge clk);
      e8++;
    end
    check("dw8_latency", e8, 3);
    check("dw8_count", out8_count, 8);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
